icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Direct-mapped instruction cache controller between the IF stage and port 0 (instruction port) of the two-port memory controller.
- Serves hits with 1-cycle latency.
- On a miss, sequences a single 4-byte read on the memory-controller port, fills the line and returns the word.
- Supports fetch cancel (flush) and whole-cache invalidate (fence.i).

Parameters:
INDEX_BITS, 6, log2 of line count (64 lines, one 32-bit word per line)
ADDR_WIDTH, 32, byte address width (equals `addrWidth)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; sampled only when if_busy=0
if_addr  in  32  fetch byte address; bits [1:0] ignored
if_flush  in  1  cancel the current or outstanding fetch
inv_all  in  1  invalidate all lines
if_rdy  out  1  one-cycle pulse, if_inst valid
if_inst  out  32  fetched instruction word
if_busy  out  1  miss in progress; new requests ignored
mem_rw_flag  out  2  to memory-controller port 0 rw_flag (2'b10 read, 2'b00 idle)
mem_addr  out  32  word-aligned line address
mem_len  out  2  byte count minus one; always 2'd3
mem_rdata  in  32  memory-controller port 0 data_out
mem_busy  in  1  memory-controller port 0 busy (monitor only)
mem_done  in  1  memory-controller port 0 done pulse

Behaviour:
- Address split: offset = addr[1:0] (ignored); index = addr[INDEX_BITS+1:2]; tag = addr[31:INDEX_BITS+2].
- Reset:
  - State goes to IDLE.
  - if_rdy, if_busy, cancel, inv_pend are 0.
  - if_inst = 0, mem_rw_flag = 2'b00, mem_addr = 0, mem_len = 0.
  - All valid bits are 0.
  - Tag/data arrays are not reset.
  - Reset during a miss abandons it. The memory controller shares rst, so no stale done is expected.
- States: IDLE, MISS_REQ, MISS_WAIT.
- IDLE:
  - Default: if_rdy <= 0.
  - If inv_all: clear all valid bits and ignore if_req this cycle.
  - Else if if_flush: ignore if_req.
  - Else if if_req and hit (valid[index] && tag match):
    - if_rdy <= 1 and if_inst <= data[index] on the next edge.
    - Stay in IDLE; back-to-back hits give 1 word per cycle.
  - Else if if_req and miss:
    - Latch tag/index.
    - mem_rw_flag <= 2'b10, mem_addr <= {if_addr[31:2], 2'b00}, mem_len <= 2'd3.
    - if_busy <= 1; go to MISS_REQ.
- MISS_REQ:
  - mem_rw_flag <= 2'b00, so the flag is asserted for exactly one clk. The memory controller latches it on the intervening negedge.
  - Go to MISS_WAIT.
- MISS_WAIT:
  - Wait for mem_done.
  - On mem_done:
    - Write data[index] = mem_rdata, tag[index] = latched tag, valid[index] = 1.
    - If cancel = 0: if_rdy <= 1, if_inst <= mem_rdata.
    - if_busy <= 0, cancel <= 0; go to IDLE.
  - if_flush in MISS_REQ or MISS_WAIT sets cancel. The fill still completes into the array, but no if_rdy is produced.
  - inv_all in MISS_REQ or MISS_WAIT sets inv_pend. On the transition to IDLE, all valid bits are cleared after the fill, so the line just filled is also invalid. The returned word, if not cancelled, is still delivered.
  - mem_done arriving in IDLE or MISS_REQ is ignored (protocol error; the bench asserts it never happens).
- Simultaneous events:
  - inv_all and if_flush together in IDLE: both honoured, nothing issued.
  - if_flush in the same cycle as mem_done: the word is suppressed.
- mem_busy is not used for sequencing; it is exposed only for assertions.

Decomposition:
- defines.vh gains: `RW_NONE 2'b00, `RW_READ 2'b10, `RW_WRITE 2'b01, `LEN_WORD 2'd3, `ICACHE_INDEX_BITS 6.
- Sub-module icache_array:
  - Valid/tag/data storage.
  - Combinational read by index, producing hit and data.
  - Synchronous single write port.
  - Synchronous flash-clear of valid bits.
- icache_ctrl holds the FSM, cancel/inv_pend flags and the memory-port drivers.

Test Plan:
- Cold miss: if_req, if_addr=0x0000_1004 -> mem_rw_flag=2'b10 for 1 cycle, mem_addr=0x1004, mem_len=3; mem_done with mem_rdata=0xDEADBEEF -> if_rdy pulse, if_inst=0xDEADBEEF, if_busy falls.
- Hit: repeat 0x1004 -> if_rdy the next cycle with 0xDEADBEEF, mem_rw_flag stays 0. Four consecutive hits give four if_rdy pulses.
- Conflict: after the 0x1004 fill, fetch 0x1104 (same index, INDEX_BITS=6) -> miss, refill with 0x12345678. Then 0x1004 -> misses again.
- Flush mid-miss: miss on 0x2000, if_flush during MISS_WAIT, mem_done with 0xAAAA5555 -> no if_rdy. A subsequent fetch of 0x2000 hits with 0xAAAA5555.
- inv_all: fill 0x1004, pulse inv_all in IDLE -> the next 0x1004 misses. inv_all during MISS_WAIT -> word is delivered, the same address misses afterwards.
- Reset mid-miss: rst asserted in MISS_WAIT -> all outputs at reset values next cycle; 0x1004 misses.

Source files
------------

// File: rtl/icache_ctrl_pkg.sv
// rtl/icache_ctrl_pkg.sv - shared constants and FSM state type for the instruction cache
package icache_ctrl_pkg;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'd3;
  localparam int ICACHE_INDEX_BITS = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MISS_REQ,
    ST_MISS_WAIT
  } state_t;

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped valid/tag/data storage with flash-clear of valid bits
module icache_array
  import icache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  input  logic [TAG_BITS-1:0]   i_rd_tag,
  output logic                  o_hit,
  output logic [31:0]           o_rd_data,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [31:0]           i_wr_data,
  input  logic                  i_clr_all
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES];

  // Clear beats a same-cycle fill so an invalidate pending across a miss wins.
  always_ff @(posedge clk) begin
    if (rst || i_clr_all) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_hit     = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
  assign o_rd_data = r_data[i_rd_index];

endmodule

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - instruction cache FSM, cancel/invalidate tracking and memory port drivers
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  input  logic                  inv_all,
  output logic                  if_rdy,
  output logic [31:0]           if_inst,
  output logic                  if_busy,
  output logic [1:0]            mem_rw_flag,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_len,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_busy,
  input  logic                  mem_done
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  state_t                r_state, w_state_nxt;
  logic                  r_if_rdy, w_if_rdy_nxt;
  logic [31:0]           r_if_inst, w_if_inst_nxt;
  logic                  r_if_busy, w_if_busy_nxt;
  logic                  r_cancel, w_cancel_nxt;
  logic                  r_inv_pend, w_inv_pend_nxt;
  logic [1:0]            r_mem_rw_flag, w_mem_rw_flag_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [1:0]            r_mem_len, w_mem_len_nxt;
  logic [TAG_BITS-1:0]   r_tag, w_tag_nxt;
  logic [INDEX_BITS-1:0] r_index, w_index_nxt;

  logic                  w_hit;
  logic [31:0]           w_rd_data;
  logic                  w_wr_en;
  logic                  w_clr_all;
  logic [INDEX_BITS-1:0] w_req_index;
  logic [TAG_BITS-1:0]   w_req_tag;
  logic                  w_unused_bits;

  assign w_req_index   = if_addr[INDEX_BITS+1:2];
  assign w_req_tag     = if_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_unused_bits = ^{mem_busy, if_addr[1:0]};

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_index (w_req_index),
    .i_rd_tag   (w_req_tag),
    .o_hit      (w_hit),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_wr_en),
    .i_wr_index (r_index),
    .i_wr_tag   (r_tag),
    .i_wr_data  (mem_rdata),
    .i_clr_all  (w_clr_all)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_if_rdy_nxt      = 1'b0;
    w_if_inst_nxt     = r_if_inst;
    w_if_busy_nxt     = r_if_busy;
    w_cancel_nxt      = r_cancel;
    w_inv_pend_nxt    = r_inv_pend;
    w_mem_rw_flag_nxt = r_mem_rw_flag;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_len_nxt     = r_mem_len;
    w_tag_nxt         = r_tag;
    w_index_nxt       = r_index;
    w_wr_en           = 1'b0;
    w_clr_all         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (inv_all) begin
          w_clr_all = 1'b1;
        end else if (if_flush) begin
          w_clr_all = 1'b0;
        end else if (if_req && w_hit) begin
          w_if_rdy_nxt  = 1'b1;
          w_if_inst_nxt = w_rd_data;
        end else if (if_req) begin
          w_tag_nxt         = w_req_tag;
          w_index_nxt       = w_req_index;
          w_mem_rw_flag_nxt = RW_READ;
          w_mem_addr_nxt    = {if_addr[ADDR_WIDTH-1:2], 2'b00};
          w_mem_len_nxt     = LEN_WORD;
          w_if_busy_nxt     = 1'b1;
          w_state_nxt       = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        w_mem_rw_flag_nxt = RW_NONE;
        w_state_nxt       = ST_MISS_WAIT;
        if (if_flush) w_cancel_nxt = 1'b1;
        if (inv_all) w_inv_pend_nxt = 1'b1;
      end
      ST_MISS_WAIT: begin
        if (if_flush) w_cancel_nxt = 1'b1;
        if (inv_all) w_inv_pend_nxt = 1'b1;
        // The fill always lands; a flush only suppresses delivery to fetch.
        if (mem_done) begin
          w_wr_en   = 1'b1;
          w_clr_all = r_inv_pend || inv_all;
          if (!(r_cancel || if_flush)) begin
            w_if_rdy_nxt  = 1'b1;
            w_if_inst_nxt = mem_rdata;
          end
          w_if_busy_nxt  = 1'b0;
          w_cancel_nxt   = 1'b0;
          w_inv_pend_nxt = 1'b0;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_if_rdy      <= 1'b0;
      r_if_inst     <= '0;
      r_if_busy     <= 1'b0;
      r_cancel      <= 1'b0;
      r_inv_pend    <= 1'b0;
      r_mem_rw_flag <= RW_NONE;
      r_mem_addr    <= '0;
      r_mem_len     <= '0;
      r_tag         <= '0;
      r_index       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_if_rdy      <= w_if_rdy_nxt;
      r_if_inst     <= w_if_inst_nxt;
      r_if_busy     <= w_if_busy_nxt;
      r_cancel      <= w_cancel_nxt;
      r_inv_pend    <= w_inv_pend_nxt;
      r_mem_rw_flag <= w_mem_rw_flag_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_len     <= w_mem_len_nxt;
      r_tag         <= w_tag_nxt;
      r_index       <= w_index_nxt;
    end
  end

  assign if_rdy      = r_if_rdy;
  assign if_inst     = r_if_inst;
  assign if_busy     = r_if_busy;
  assign mem_rw_flag = r_mem_rw_flag;
  assign mem_addr    = r_mem_addr;
  assign mem_len     = r_mem_len;

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - directed bench with a line-level cache model for icache_ctrl
module tb_icache_ctrl;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        inv_all;
  logic        if_rdy;
  logic [31:0] if_inst;
  logic        if_busy;
  logic [1:0]  mem_rw_flag;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_done;

  icache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_flush    (if_flush),
    .inv_all     (inv_all),
    .if_rdy      (if_rdy),
    .if_inst     (if_inst),
    .if_busy     (if_busy),
    .mem_rw_flag (mem_rw_flag),
    .mem_addr    (mem_addr),
    .mem_len     (mem_len),
    .mem_rdata   (mem_rdata),
    .mem_busy    (mem_busy),
    .mem_done    (mem_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cache contents as the fetch unit should see them.
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];

  logic        e_rdy, e_busy, e_rst;
  logic [31:0] e_inst, e_addr;
  logic [1:0]  e_flag;
  bit          chk_en;

  int n_chk, n_pass, n_rdy, n_flag;
  logic [31:0] cap_inst, cap_addr;
  int f0, r0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  task automatic tick(input bit r, input bit rq, input logic [31:0] a, input bit fl,
                      input bit iv, input bit dn, input logic [31:0] rd,
                      input bit x_rdy, input logic [31:0] x_inst, input bit x_busy,
                      input logic [1:0] x_flag, input logic [31:0] x_addr, input bit x_rst);
    @(negedge clk);
    rst = r; if_req = rq; if_addr = a; if_flush = fl; inv_all = iv;
    mem_done = dn; mem_rdata = rd; mem_busy = 1'b0;
    e_rdy = x_rdy; e_inst = x_inst; e_busy = x_busy;
    e_flag = x_flag; e_addr = x_addr; e_rst = x_rst;
    chk_en = 1'b1;
  endtask

  task automatic idle();
    tick(0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 2'b00, 32'h0, 0);
  endtask

  // One fetch from request to completion; k counts cycles after the request edge.
  task automatic fetch(input logic [31:0] a, input logic [31:0] md, input int wt,
                       input int fl_at, input int iv_at, input int rs_at);
    int idx;
    logic [23:0] tg;
    bit cancel, inv, fl, iv, dn;
    int done_k;
    idx = int'(a[7:2]);
    tg  = a[31:8];
    if (m_valid[idx] && m_tag[idx] == tg) begin
      tick(0, 1, a, 0, 0, 0, 32'h0, 1, m_data[idx], 0, 2'b00, 32'h0, 0);
      return;
    end
    tick(0, 1, a, 0, 0, 0, 32'h0, 0, 32'h0, 1, 2'b10, {a[31:2], 2'b00}, 0);
    cancel = 0; inv = 0;
    done_k = 2 + wt;
    for (int k = 1; k <= done_k; k++) begin
      if (k == rs_at) begin
        tick(1, 1, a, 0, 0, 0, 32'h0, 0, 32'h0, 0, 2'b00, 32'h0, 1);
        clear_model();
        tick(0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 2'b00, 32'h0, 1);
        return;
      end
      fl = (k == fl_at);
      iv = (k == iv_at);
      dn = (k == done_k);
      cancel |= fl;
      inv |= iv;
      if (dn) begin
        tick(0, 1, a, fl, iv, 1, md, !cancel, md, 0, 2'b00, 32'h0, 0);
        m_data[idx] = md; m_tag[idx] = tg; m_valid[idx] = 1'b1;
        if (inv) clear_model();
      end else begin
        tick(0, 1, a, fl, iv, 0, 32'h0, 0, 32'h0, 1, 2'b00, 32'h0, 0);
      end
    end
    idle();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        chk("if_rdy", {31'h0, if_rdy}, {31'h0, e_rdy});
        chk("if_busy", {31'h0, if_busy}, {31'h0, e_busy});
        chk("mem_rw_flag", {30'h0, mem_rw_flag}, {30'h0, e_flag});
        if (e_rdy) chk("if_inst", if_inst, e_inst);
        if (e_flag == 2'b10) begin
          chk("mem_addr", mem_addr, e_addr);
          chk("mem_len", {30'h0, mem_len}, 32'd3);
        end
        if (e_rst) begin
          chk("rst_inst", if_inst, 32'h0);
          chk("rst_addr", mem_addr, 32'h0);
          chk("rst_len", {30'h0, mem_len}, 32'h0);
        end
        if (if_rdy) begin n_rdy++; cap_inst = if_inst; end
        if (mem_rw_flag == 2'b10) begin n_flag++; cap_addr = mem_addr; end
      end
    end
  end

  initial begin
    rst = 1; if_req = 0; if_addr = 0; if_flush = 0; inv_all = 0;
    mem_rdata = 0; mem_busy = 0; mem_done = 0;
    n_chk = 0; n_pass = 0; n_rdy = 0; n_flag = 0; chk_en = 0;
    cap_inst = 0; cap_addr = 0;
    e_rdy = 0; e_inst = 0; e_busy = 0; e_flag = 0; e_addr = 0; e_rst = 1;
    clear_model();

    tick(1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 2'b00, 32'h0, 1);
    tick(1, 1, 32'h1004, 0, 0, 0, 32'h0, 0, 32'h0, 0, 2'b00, 32'h0, 1);

    // Cold miss
    f0 = n_flag; r0 = n_rdy;
    fetch(32'h1004, 32'hDEADBEEF, 2, -1, -1, -1);
    chk("cold_inst", cap_inst, 32'hDEADBEEF);
    chk("cold_addr", cap_addr, 32'h0000_1004);
    chk("cold_flag_cycles", n_flag - f0, 1);
    chk("model_tag1", {8'h0, m_tag[1]}, 32'h10);

    // Four back-to-back hits
    f0 = n_flag; r0 = n_rdy;
    for (int i = 0; i < 4; i++) fetch(32'h1004, 32'h0, 0, -1, -1, -1);
    idle();
    chk("hit_pulses", n_rdy - r0, 4);
    chk("hit_no_mem", n_flag - f0, 0);
    chk("hit_inst", cap_inst, 32'hDEADBEEF);

    // Conflict on index 1
    f0 = n_flag;
    fetch(32'h1104, 32'h12345678, 1, -1, -1, -1);
    chk("conflict_inst", cap_inst, 32'h12345678);
    fetch(32'h1004, 32'hDEADBEEF, 0, -1, -1, -1);
    chk("conflict_refetch", n_flag - f0, 2);

    // Flush during MISS_WAIT
    r0 = n_rdy;
    fetch(32'h2000, 32'hAAAA5555, 3, 3, -1, -1);
    chk("flush_no_rdy", n_rdy - r0, 0);
    f0 = n_flag;
    fetch(32'h2000, 32'h0, 0, -1, -1, -1);
    idle();
    chk("flush_fill_hit", cap_inst, 32'hAAAA5555);
    chk("flush_hit_no_mem", n_flag - f0, 0);

    // Flush alone, flush+inv together, in IDLE
    r0 = n_rdy;
    tick(0, 1, 32'h1004, 1, 0, 0, 32'h0, 0, 32'h0, 0, 2'b00, 32'h0, 0);
    idle();
    chk("idle_flush_ignored", n_rdy - r0, 0);
    tick(0, 1, 32'h1004, 1, 1, 0, 32'h0, 0, 32'h0, 0, 2'b00, 32'h0, 0);
    clear_model();
    idle();
    f0 = n_flag;
    fetch(32'h1004, 32'hDEADBEEF, 0, -1, -1, -1);
    chk("flush_inv_miss", n_flag - f0, 1);

    // inv_all in IDLE
    tick(0, 1, 32'h1004, 0, 1, 0, 32'h0, 0, 32'h0, 0, 2'b00, 32'h0, 0);
    clear_model();
    f0 = n_flag;
    fetch(32'h1004, 32'hDEADBEEF, 1, -1, -1, -1);
    chk("inv_idle_miss", n_flag - f0, 1);

    // inv_all during MISS_WAIT: word delivered, line not kept
    r0 = n_rdy;
    fetch(32'h3000, 32'h0BADF00D, 2, -1, 2, -1);
    chk("inv_wait_deliver", n_rdy - r0, 1);
    chk("inv_wait_inst", cap_inst, 32'h0BADF00D);
    f0 = n_flag;
    fetch(32'h3000, 32'h0BADF00D, 0, -1, -1, -1);
    chk("inv_wait_refetch", n_flag - f0, 1);

    // Flush coincident with mem_done, inv in MISS_REQ
    r0 = n_rdy;
    fetch(32'h4000, 32'h5A5A0F0F, 1, 3, 1, -1);
    chk("flush_at_done", n_rdy - r0, 0);

    // Reset during MISS_WAIT
    fetch(32'h1004, 32'hDEADBEEF, 0, -1, -1, -1);
    fetch(32'h5000, 32'h11112222, 3, -1, -1, 3);
    f0 = n_flag;
    fetch(32'h1004, 32'hCAFEF00D, 0, -1, -1, -1);
    chk("rst_then_miss", n_flag - f0, 1);
    chk("rst_refill_inst", cap_inst, 32'hCAFEF00D);

    idle();
    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
